alu_arbiter: RTL and testbench

- Two-port round-robin scheduler that shares the single 16-bit combinational ALU between two requesters, port A and port B.
- Each accepted request is latched, driven onto the ALU operand/operator bus and held for one execute cycle.
- The result is captured and returned to the issuing port with a valid/ready handshake.
- The arbiter guards divide/modulo by zero and illegal opcodes.
- It also keeps a completed-operation counter.

---
 rtl/alu_arbiter.sv | 177 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between ports A and B.
// One operation in flight: accept (IDLE), execute (EXEC), return result (RESP).
module alu_arbiter #(
    parameter int unsigned    WIDTH  = 16,
    parameter int unsigned    OPW    = 4,
    parameter logic [OPW-1:0] NOP_OP = OPW'('hF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [OPW-1:0]   a_op,
    input  logic [WIDTH-1:0] a_op1,
    input  logic [WIDTH-1:0] a_op2,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [OPW-1:0]   b_op,
    input  logic [WIDTH-1:0] b_op1,
    input  logic [WIDTH-1:0] b_op2,
    output logic             a_resp_valid,
    input  logic             a_resp_ready,
    output logic             b_resp_valid,
    input  logic             b_resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic [OPW-1:0]   alu_operator,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int unsigned    CNTW    = 16;
    localparam logic [OPW-1:0] OP_DIV  = OPW'(4);
    localparam logic [OPW-1:0] OP_MOD  = OPW'(5);
    localparam logic [OPW-1:0] OP_LAST = OPW'(7);
    localparam logic           GRANT_A = 1'b0;
    localparam logic           GRANT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [OPW-1:0]    alu_operator_q, alu_operator_d;
    logic [WIDTH-1:0]  alu_op1_q, alu_op1_d;
    logic [WIDTH-1:0]  alu_op2_q, alu_op2_d;
    logic [WIDTH-1:0]  resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              a_resp_valid_q, a_resp_valid_d;
    logic              b_resp_valid_q, b_resp_valid_d;
    logic              busy_q, busy_d;
    logic [CNTW-1:0]   op_count_q, op_count_d;

    logic grant_a, grant_b, div_fault, resp_hs;

    // Under contention the port that did not win last time is granted.
    assign grant_a = (state_q == IDLE) && a_valid && (!b_valid || (last_grant_q == GRANT_B));
    assign grant_b = (state_q == IDLE) && b_valid && (!a_valid || (last_grant_q == GRANT_A));

    assign div_fault = ((alu_operator_q == OP_DIV) || (alu_operator_q == OP_MOD))
                       && (alu_op2_q == WIDTH'(0));
    assign resp_hs   = (a_resp_valid_q && a_resp_ready) || (b_resp_valid_q && b_resp_ready);

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        alu_operator_d = alu_operator_q;
        alu_op1_d      = alu_op1_q;
        alu_op2_d      = alu_op2_q;
        resp_data_d    = resp_data_q;
        resp_err_d     = resp_err_q;
        a_resp_valid_d = a_resp_valid_q;
        b_resp_valid_d = b_resp_valid_q;
        busy_d         = busy_q;
        op_count_d     = op_count_q;

        case (state_q)
            IDLE: begin
                alu_operator_d = NOP_OP;
                if (grant_a) begin
                    alu_operator_d = a_op;
                    alu_op1_d      = a_op1;
                    alu_op2_d      = a_op2;
                    last_grant_d   = GRANT_A;
                    busy_d         = 1'b1;
                    state_d        = EXEC;
                end else if (grant_b) begin
                    alu_operator_d = b_op;
                    alu_op1_d      = b_op1;
                    alu_op2_d      = b_op2;
                    last_grant_d   = GRANT_B;
                    busy_d         = 1'b1;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                // Illegal opcodes and zero divisors never return the ALU value.
                if (alu_operator_q > OP_LAST) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                end else if (div_fault) begin
                    resp_data_d = {WIDTH{1'b1}};
                    resp_err_d  = 1'b1;
                end else begin
                    resp_data_d = alu_out;
                    resp_err_d  = 1'b0;
                end
                a_resp_valid_d = (last_grant_q == GRANT_A);
                b_resp_valid_d = (last_grant_q == GRANT_B);
                state_d        = RESP;
            end
            RESP: begin
                if (resp_hs) begin
                    a_resp_valid_d = 1'b0;
                    b_resp_valid_d = 1'b0;
                    op_count_d     = op_count_q + CNTW'(1);
                    alu_operator_d = NOP_OP;
                    busy_d         = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: begin
                a_resp_valid_d = 1'b0;
                b_resp_valid_d = 1'b0;
                alu_operator_d = NOP_OP;
                busy_d         = 1'b0;
                state_d        = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            last_grant_q   <= GRANT_B;
            alu_operator_q <= NOP_OP;
            alu_op1_q      <= '0;
            alu_op2_q      <= '0;
            resp_data_q    <= '0;
            resp_err_q     <= 1'b0;
            a_resp_valid_q <= 1'b0;
            b_resp_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            op_count_q     <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            alu_operator_q <= alu_operator_d;
            alu_op1_q      <= alu_op1_d;
            alu_op2_q      <= alu_op2_d;
            resp_data_q    <= resp_data_d;
            resp_err_q     <= resp_err_d;
            a_resp_valid_q <= a_resp_valid_d;
            b_resp_valid_q <= b_resp_valid_d;
            busy_q         <= busy_d;
            op_count_q     <= op_count_d;
        end
    end

    assign a_ready      = grant_a;
    assign b_ready      = grant_b;
    assign a_resp_valid = a_resp_valid_q;
    assign b_resp_valid = b_resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_err     = resp_err_q;
    assign alu_operator = alu_operator_q;
    assign alu_op1      = alu_op1_q;
    assign alu_op2      = alu_op2_q;
    assign busy         = busy_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a behavioural ALU and
// a transaction-level reference model of grants, responses and the op counter.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OPW   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, b_valid, a_ready, b_ready;
    logic [OPW-1:0]   a_op, b_op;
    logic [WIDTH-1:0] a_op1, a_op2, b_op1, b_op2;
    logic             a_resp_valid, a_resp_ready, b_resp_valid, b_resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;
    logic [OPW-1:0]   alu_operator;
    logic [WIDTH-1:0] alu_op1, alu_op2, alu_out;
    logic             busy;
    logic [15:0]      op_count;

    int vectors = 0;
    int miscompares = 0;

    // Pending request per port (0 = A, 1 = B) and model state.
    bit               pv [2];
    logic [OPW-1:0]   pop[2];
    logic [WIDTH-1:0] px [2];
    logic [WIDTH-1:0] py [2];
    bit               last;
    logic [15:0]      cnt;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_op1(a_op1), .a_op2(a_op2),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_op1(b_op1), .b_op2(b_op2),
        .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
        .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_operator(alu_operator), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_out(alu_out), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stand-in ALU; junk values on faulting cases expose a missing guard.
    always_comb begin
        case (alu_operator)
            4'd0: alu_out = alu_op1 + alu_op2;
            4'd1: alu_out = alu_op1 - alu_op2;
            4'd2: alu_out = alu_op1 * alu_op2;
            4'd3: alu_out = ~(alu_op1 & alu_op2);
            4'd4: alu_out = (alu_op2 == 16'd0) ? 16'h5A5A : alu_op1 / alu_op2;
            4'd5: alu_out = (alu_op2 == 16'd0) ? 16'h5A5A : alu_op1 % alu_op2;
            4'd6: alu_out = {15'd0, alu_op1 < alu_op2};
            4'd7: alu_out = {15'd0, alu_op1 <= alu_op2};
            default: alu_out = 16'hA5A5;
        endcase
    end

    function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        int unsigned ux, uy, r;
        ux = 32'(x);
        uy = 32'(y);
        if (op > 4'd7) return {1'b1, 16'h0000};
        if ((op == 4'd4 || op == 4'd5) && y == 16'd0) return {1'b1, 16'hFFFF};
        case (op)
            4'd0: r = ux + uy;
            4'd1: r = ux - uy;
            4'd2: r = ux * uy;
            4'd3: r = ~(ux & uy);
            4'd4: r = ux / uy;
            4'd5: r = ux % uy;
            4'd6: r = (ux < uy) ? 1 : 0;
            default: r = (ux <= uy) ? 1 : 0;
        endcase
        return {1'b0, 16'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reqs();
        a_valid = pv[0]; a_op = pop[0]; a_op1 = px[0]; a_op2 = py[0];
        b_valid = pv[1]; b_op = pop[1]; b_op1 = px[1]; b_op2 = py[1];
    endtask

    task automatic set_req(input int p, input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        pv[p] = 1'b1; pop[p] = op; px[p] = x; py[p] = y;
        apply_reqs();
    endtask

    task automatic rand_req(input int p);
        logic [3:0] op;
        logic [15:0] y;
        op = 4'($urandom_range(0, 9));
        if (op > 4'd7) op = 4'($urandom_range(8, 15));
        y = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
        set_req(p, op, 16'($urandom), y);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_operator"}, 32'(alu_operator), 32'hF);
        chk({tag, "_op1"}, 32'(alu_op1), 0);
        chk({tag, "_op2"}, 32'(alu_op2), 0);
        chk({tag, "_rvalid"}, 32'({a_resp_valid, b_resp_valid}), 0);
        chk({tag, "_data"}, 32'(resp_data), 0);
        chk({tag, "_err"}, 32'(resp_err), 0);
        chk({tag, "_count"}, 32'(op_count), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pv[0] = 0; pv[1] = 0; apply_reqs();
        a_resp_ready = 0; b_resp_ready = 0;
        rst = 1'b0;
        #1 check_reset_values("rst");
        @(negedge clk);
        rst = 1'b1;
        cnt = 16'd0;
        last = 1'b1;
    endtask

    task automatic wait_grant(output bit port, output bit ok, output int waited);
        ok = 0; port = 0; waited = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (a_ready || b_ready) begin
                ok = 1; port = b_ready; waited = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One full transaction: grant, execute, response with optional backpressure.
    task automatic serve(input int stall, output int waited);
        bit port, ok, exp_port;
        logic [3:0] op;
        logic [16:0] exp;
        exp_port = (pv[0] && pv[1]) ? ~last : pv[1];
        wait_grant(port, ok, waited);
        chk("grant_seen", 32'(ok), 1);
        if (!ok) return;
        chk("grant_port", 32'(port), 32'(exp_port));
        chk("ready_onehot", 32'(a_ready && b_ready), 0);
        op = pop[port];
        exp = model(op, px[port], py[port]);
        last = port;
        @(negedge clk);
        pv[port] = 0; apply_reqs();
        #1;
        chk("exec_busy", 32'(busy), 1);
        chk("exec_ready", 32'({a_ready, b_ready}), 0);
        chk("exec_rvalid", 32'({a_resp_valid, b_resp_valid}), 0);
        chk("exec_operator", 32'(alu_operator), 32'(op));
        @(negedge clk);
        for (int s = 0; s <= stall; s++) begin
            #1;
            chk("resp_valid", 32'({a_resp_valid, b_resp_valid}), port ? 32'h1 : 32'h2);
            chk("resp_data", 32'(resp_data), 32'(exp[15:0]));
            chk("resp_err", 32'(resp_err), 32'(exp[16]));
            chk("resp_ready_low", 32'({a_ready, b_ready}), 0);
            if (s < stall) @(negedge clk);
        end
        if (port) b_resp_ready = 1; else a_resp_ready = 1;
        @(negedge clk);
        a_resp_ready = 0; b_resp_ready = 0;
        cnt = cnt + 16'd1;
        #1;
        chk("done_count", 32'(op_count), 32'(cnt));
        chk("done_rvalid", 32'({a_resp_valid, b_resp_valid}), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_operator", 32'(alu_operator), 32'hF);
    endtask

    initial begin
        bit port, ok;
        int w;
        rst = 1'b1;
        a_resp_ready = 0; b_resp_ready = 0;
        pv[0] = 0; pv[1] = 0;
        pop[0] = 0; pop[1] = 0; px[0] = 0; px[1] = 0; py[0] = 0; py[1] = 0;
        apply_reqs();
        cnt = 0; last = 1'b1;

        // Single ADD on port A.
        do_reset();
        set_req(0, 4'd0, 16'h0003, 16'h0004);
        serve(0, w);
        chk("add_count_one", 32'(op_count), 1);

        // Contention: grants alternate A,B,A,B starting with A after reset.
        do_reset();
        set_req(0, 4'd1, 16'd10, 16'd3);
        set_req(1, 4'd2, 16'h0100, 16'h0100);
        for (int i = 0; i < 8; i++) begin
            serve(0, w);
            chk("alt_grant", 32'(last), 32'(i % 2));
            if (i < 6) rand_req(int'(last));
        end

        // Backpressure on A with B waiting; B must win the very next cycle.
        rand_req(0);
        rand_req(1);
        serve(5, w);
        #1 chk("bp_b_ready", 32'(b_ready), 1);
        serve(0, w);
        chk("bp_b_next_cycle", 32'(w), 0);

        // Divide/modulo by zero and an illegal opcode on port B.
        set_req(1, 4'd4, 16'h0010, 16'h0000);
        serve(0, w);
        set_req(1, 4'd5, 16'h0010, 16'h0000);
        serve(0, w);
        set_req(1, 4'hC, 16'h1234, 16'h5678);
        serve(0, w);

        // Reset during EXEC abandons the operation.
        set_req(0, 4'd0, 16'd5, 16'd6);
        wait_grant(port, ok, w);
        chk("rx_grant_seen", 32'(ok), 1);
        @(negedge clk);
        pv[0] = 0; apply_reqs();
        #1 chk("rx_in_exec", 32'(busy), 1);
        rst = 1'b0;
        #1 check_reset_values("rx");
        @(negedge clk);
        rst = 1'b1;
        cnt = 16'd0; last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("rx_no_resp", 32'({a_resp_valid, b_resp_valid, busy}), 0);
        end

        // Counter wrap from 0xFFFF to 0.
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        #1 chk("wrap_preload", 32'(op_count), 32'hFFFF);
        cnt = 16'hFFFF;
        set_req(0, 4'd3, 16'hF0F0, 16'hFF00);
        serve(0, w);
        chk("wrap_zero", 32'(op_count), 0);

        // Randomized mix of ports, operations and backpressure.
        for (int i = 0; i < 40; i++) begin
            if (!pv[0] && $urandom_range(0, 1) == 1) rand_req(0);
            if (!pv[1] && $urandom_range(0, 1) == 1) rand_req(1);
            if (!pv[0] && !pv[1]) rand_req(int'($urandom_range(0, 1)));
            serve(int'($urandom_range(0, 3)), w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
